sprite_motion: RTL and testbench

- Sprite position controller that drives `sprx`/`spry` and `spr_start` into the sprite_v3 line renderer in the 1080p sprite tops.
- Once per frame, at the start of vertical blanking, it updates the position for both axes and bounces off all four screen edges.
- It generates the sprite start pulse in the blanking of the line before the sprite's first line, wrapping correctly when `spry` is 0.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_axis.sv | 55 +++++
 rtl/sprite_motion.sv | 93 +++++++++
 tb/tb_sprite_motion.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared 1080p raster constants, coordinate type and direction encoding
// for the sprite motion block.
package sprite_pkg;

  localparam int CORDW      = 12;
  localparam int H_RES      = 1920;
  localparam int V_RES      = 1080;
  localparam int H_RES_FULL = 2200;
  localparam int V_RES_FULL = 1125;

  typedef logic [CORDW-1:0] coord_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_t;

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: position, direction and bounce flag, stepped
// once per update strobe and reflected off both screen edges.
module sprite_axis
  import sprite_pkg::*;
#(
  parameter int W      = 12,
  parameter int RES    = 1920,
  parameter int SPR_PX = 144,
  parameter int SPEED  = 12,
  parameter int INIT   = 888
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd,
  output logic [W-1:0] pos,
  output dir_t         dir,
  output logic         bounce
);

  // Far-edge threshold: at or beyond it the next step must head back.
  localparam logic [W-1:0] HI   = W'(RES - SPR_PX - SPEED);
  localparam logic [W-1:0] STEP = W'(SPEED);

  generate
    if (RES <= SPR_PX + 2 * SPEED) begin : g_bad_bounds
      $error("sprite_axis: RES must exceed SPR_PX + 2*SPEED");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= W'(INIT);
      dir    <= DIR_FWD;
      bounce <= 1'b0;
    end else begin
      bounce <= 1'b0;
      if (upd && (SPEED != 0)) begin
        if (pos >= HI) begin
          dir    <= DIR_REV;
          pos    <= pos - STEP;
          bounce <= 1'b1;
        end else if (pos < STEP) begin
          dir    <= DIR_FWD;
          pos    <= pos + STEP;
          bounce <= 1'b1;
        end else if (dir == DIR_REV) begin
          pos <= pos - STEP;
        end else begin
          pos <= pos + STEP;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// Bouncing sprite position controller with line-start strobe for the renderer.
// Optional macro SPRITE_MOTION_FRAME_DIV_EN: update only every FRAME_DIV frames.
module sprite_motion #(
  parameter int CORDW      = sprite_pkg::CORDW,
  parameter int H_RES      = sprite_pkg::H_RES,
  parameter int V_RES      = sprite_pkg::V_RES,
  parameter int V_RES_FULL = sprite_pkg::V_RES_FULL,
  parameter int SPR_W_PX   = 144,
  parameter int SPR_H_PX   = 144,
  parameter int SPEED_X    = 12,
  parameter int SPEED_Y    = 4,
  parameter int INIT_X     = 888,
  parameter int INIT_Y     = 468
`ifdef SPRITE_MOTION_FRAME_DIV_EN
  , parameter int FRAME_DIV = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             en,
  output logic [CORDW-1:0] sprx,
  output logic [CORDW-1:0] spry,
  output logic             dx,
  output logic             dy,
  output logic             hit,
  output logic             spr_start
);

  import sprite_pkg::dir_t, sprite_pkg::DIR_REV;

  logic             tick;
  logic             upd;
  logic             bounce_x;
  logic             bounce_y;
  dir_t             dir_x;
  dir_t             dir_y;
  logic [CORDW-1:0] spry_cor;

  // First pixel of vertical blanking.
  assign tick = (sy == CORDW'(V_RES)) && (sx == '0);

`ifdef SPRITE_MOTION_FRAME_DIV_EN
  localparam int CNTW = $clog2(FRAME_DIV + 1);

  logic [CNTW-1:0] frame_cnt;
  logic            frame_last;

  generate
    if (FRAME_DIV < 1) begin : g_bad_div
      $error("sprite_motion: FRAME_DIV must be at least 1");
    end
  endgenerate

  assign frame_last = (frame_cnt == CNTW'(FRAME_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (tick && en) begin
      frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
    end
  end

  assign upd = tick && en && frame_last;
`else
  assign upd = tick && en;
`endif

  sprite_axis #(
    .W(CORDW), .RES(H_RES), .SPR_PX(SPR_W_PX), .SPEED(SPEED_X), .INIT(INIT_X)
  ) u_axis_x (
    .clk(clk), .rst_n(rst_n), .upd(upd),
    .pos(sprx), .dir(dir_x), .bounce(bounce_x)
  );

  sprite_axis #(
    .W(CORDW), .RES(V_RES), .SPR_PX(SPR_H_PX), .SPEED(SPEED_Y), .INIT(INIT_Y)
  ) u_axis_y (
    .clk(clk), .rst_n(rst_n), .upd(upd),
    .pos(spry), .dir(dir_y), .bounce(bounce_y)
  );

  assign dx  = (dir_x == DIR_REV);
  assign dy  = (dir_y == DIR_REV);
  assign hit = bounce_x | bounce_y;

  // Line before the sprite's top row, wrapping to the last blanking line.
  assign spry_cor  = (spry == '0) ? CORDW'(V_RES_FULL - 1) : spry - CORDW'(1);
  assign spr_start = (sy == spry_cor) && (sx == CORDW'(H_RES));

endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: bounce/reset/freeze/start-wrap directed cases
// followed by randomized frames against a trajectory model.
module tb_sprite_motion;

  localparam int H_RES  = 1920;
  localparam int V_RES  = 1080;
  localparam int V_FULL = 1125;
  localparam int SPR    = 144;
  localparam int SPD_X  = 12;
  localparam int SPD_Y  = 4;
  localparam int W      = 27;
`ifdef SPRITE_MOTION_FRAME_DIV_EN
  localparam int TPU = 4;
`else
  localparam int TPU = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sx, sy;
  logic        en;
  logic [11:0] sprx, spry;
  logic        dx, dy, hit, spr_start;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  bit last_hit;

  int m_x, m_y, m_cnt;
  bit m_dx, m_dy, m_hit;
  logic [W-1:0] exp_q[$];

  sprite_motion dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .en(en),
    .sprx(sprx), .spry(spry), .dx(dx), .dy(dy), .hit(hit),
    .spr_start(spr_start)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: one bounce step of a single axis
  function automatic void axis_step(inout int p, inout bit d, output bit b,
                                    input int res, input int spd);
    int hi;
    hi = res - SPR - spd;
    b  = 0;
    if (spd == 0) return;
    if (p >= hi) begin
      d = 1; p = p - spd; b = 1;
    end else if (p < spd) begin
      d = 0; p = p + spd; b = 1;
    end else begin
      p = d ? p - spd : p + spd;
    end
  endfunction

  initial begin
    bit bx, by;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_x = 888; m_y = 468; m_dx = 0; m_dy = 0; m_hit = 0; m_cnt = 0;
        exp_q.delete();
      end else begin
        m_hit = 0;
        if (int'(sy) == V_RES && int'(sx) == 0 && en) begin
          m_cnt++;
          if (m_cnt == TPU) begin
            m_cnt = 0;
            axis_step(m_x, m_dx, bx, H_RES, SPD_X);
            axis_step(m_y, m_dy, by, V_RES, SPD_Y);
            m_hit = bx | by;
          end
        end
      end
      exp_q.push_back({12'(m_x), 12'(m_y), m_dx, m_dy, m_hit});
      chk_en = 1;
    end
  end

  // Scoreboard compare on the falling edge
  initial begin
    logic [W-1:0] e, got;
    int  ey;
    bit  exp_s;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty got size=0 want size>=1 at %0t", $time);
        end else begin
          e   = exp_q.pop_front();
          got = {sprx, spry, dx, dy, hit};
          if (got !== e) begin
            n_fail++;
            $display("FAIL state got x=%0d y=%0d dx=%0d dy=%0d hit=%0d want x=%0d y=%0d dx=%0d dy=%0d hit=%0d at %0t",
                     sprx, spry, dx, dy, hit, e[26:15], e[14:3], e[2], e[1], e[0], $time);
          end
          ey    = int'(e[14:3]);
          exp_s = (int'(sx) == H_RES) && (int'(sy) == (ey + V_FULL - 1) % V_FULL);
          n_tests++;
          if (spr_start !== exp_s) begin
            n_fail++;
            $display("FAIL spr_start got %0d want %0d (sx=%0d sy=%0d spry=%0d) at %0t",
                     spr_start, exp_s, sx, sy, ey, $time);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input int xv, input int yv, input bit ev);
    sx = 12'(xv);
    sy = 12'(yv);
    en = ev;
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd_en(input bit hold);
    return hold ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction

  task automatic frame(input bit ten, input bit hold);
    int sl;
    step($urandom_range(1, 2199), $urandom_range(0, V_FULL - 1), rnd_en(hold));
    step(0, V_RES - 1, rnd_en(hold));
    step(1, V_RES, rnd_en(hold));
    step(0, V_RES, ten);
    last_hit = hit;
    sl = (m_y + V_FULL - 1) % V_FULL;
    step(H_RES, sl, rnd_en(hold));
    step(H_RES - 1, sl, rnd_en(hold));
    step(H_RES, (sl + 1) % V_FULL, rnd_en(hold));
    step(H_RES, V_FULL - 1, rnd_en(hold));
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b1, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_x", int'(sprx), 888);
    chk("rst_async_y", int'(spry), 468);
    chk("rst_async_dx", int'(dx), 0);
    chk("rst_async_dy", int'(dy), 0);
    chk("rst_async_hit", int'(hit), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sx = '0; sy = '0; en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_x", int'(sprx), 888);
    chk("reset_y", int'(spry), 468);
    chk("reset_hit", int'(hit), 0);
    sx = 12'(H_RES); sy = 12'd467; en = 1'b0;
    #1 chk("start_468", int'(spr_start), 1);
    sy = 12'd468;
    #1 chk("start_468_off", int'(spr_start), 0);
    @(posedge clk); #1;

    frames(5 * TPU);
    sx = 12'd700; sy = 12'd300;
    async_reset();

    frames(TPU);
    chk("first_x", int'(sprx), 900);
    chk("first_y", int'(spry), 472);

    repeat (3) frame(1'b0, 1'b1);
    chk("freeze_x", int'(sprx), 900);
    chk("freeze_y", int'(spry), 472);

    frames(TPU);
    chk("resume_x", int'(sprx), 912);
    chk("resume_y", int'(spry), 476);

    frames(72 * TPU);
    chk("rbounce_x", int'(sprx), 1752);
    chk("rbounce_y", int'(spry), 764);
    chk("rbounce_dx", int'(dx), 1);
    chk("rbounce_hit", int'(last_hit), 1);

    frames(43 * TPU);
    chk("bbounce_x", int'(sprx), 1236);
    chk("bbounce_y", int'(spry), 928);
    chk("bbounce_dy", int'(dy), 1);
    chk("bbounce_hit", int'(last_hit), 1);

    frames(232 * TPU);
    chk("top_x", int'(sprx), 1548);
    chk("top_dx", int'(dx), 0);
    chk("top_y", int'(spry), 0);
    sx = 12'(H_RES); sy = 12'd1124; en = 1'b0;
    #1 chk("start_wrap", int'(spr_start), 1);
    sy = 12'd1123;
    #1 chk("start_wrap_off", int'(spr_start), 0);
    @(posedge clk); #1;

    repeat (150) frame(1'($urandom_range(0, 3) != 0), 1'b0);
    sx = 12'($urandom_range(1, 2199)); sy = 12'($urandom_range(0, 1079));
    async_reset();
    repeat (150) frame(1'($urandom_range(0, 3) != 0), 1'b0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
